// File: rtl/spmv_row_sequencer.sv
// CSR row sequencer: walks the row-pointer word, fetches packed column-index
// and FP16 value words through a single SRAM read port (one-word caches for
// each), and streams one non-zero per handshake tagged with its row.
module spmv_row_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [4:0]        i_num_rows,
  input  logic [ADDR_W-1:0] i_ptr_addr,
  input  logic [ADDR_W-1:0] i_col_addr,
  input  logic [ADDR_W-1:0] i_val_addr,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_nz_valid,
  input  logic              i_nz_ready,
  output logic [4:0]        o_nz_row,
  output logic [3:0]        o_nz_col,
  output logic [15:0]       o_nz_val,
  output logic              o_row_done,
  output logic [4:0]        o_done_row,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_PTR_RD, S_PTR_CAP, S_ROW_SETUP, S_COL_RD, S_COL_CAP,
    S_VAL_RD, S_VAL_CAP, S_EMIT, S_ROW_END, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        num_rows_q, row_q;
  logic [ADDR_W-1:0] col_addr_q, val_addr_q, ptr_addr_q;
  logic [DATA_W-1:0] ptr_word_q, col_word_q, val_word_q;
  logic [ADDR_W-1:0] col_tag_q, val_tag_q;
  logic              col_vld_q, val_vld_q;
  logic [7:0]        k_q, end_q;
  logic              done_q;

  logic [7:0]        p_r, p_r1, k_chk;
  logic [ADDR_W-1:0] col_need, val_need;
  logic              col_hit, val_hit, row_last;

  assign p_r      = ptr_word_q[{row_q, 3'b000} +: 8];
  assign p_r1     = ptr_word_q[{row_q + 5'd1, 3'b000} +: 8];
  assign row_last = (row_q + 5'd1) == num_rows_q;

  // Cache lookup uses the index that will be current after this cycle:
  // the row start in ROW_SETUP, the successor index in EMIT.
  always_comb begin
    k_chk = k_q;
    if (state_q == S_ROW_SETUP) k_chk = p_r;
    else if (state_q == S_EMIT) k_chk = k_q + 8'd1;
    col_need = col_addr_q + ADDR_W'(k_chk[7:6]);
    val_need = val_addr_q + ADDR_W'(k_chk[7:4]);
    col_hit  = col_vld_q && (col_tag_q == col_need);
    val_hit  = val_vld_q && (val_tag_q == val_need);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; column fetch always precedes value fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_start) state_d = (i_num_rows == 5'd0) ? S_DONE : S_PTR_RD;
      S_PTR_RD:    state_d = S_PTR_CAP;
      S_PTR_CAP:   state_d = S_ROW_SETUP;
      S_ROW_SETUP: begin
        if (p_r1 <= p_r)   state_d = S_ROW_END;
        else if (!col_hit) state_d = S_COL_RD;
        else if (!val_hit) state_d = S_VAL_RD;
        else               state_d = S_EMIT;
      end
      S_COL_RD:    state_d = S_COL_CAP;
      S_COL_CAP:   state_d = val_hit ? S_EMIT : S_VAL_RD;
      S_VAL_RD:    state_d = S_VAL_CAP;
      S_VAL_CAP:   state_d = S_EMIT;
      S_EMIT: begin
        if (i_nz_ready) begin
          if ((k_q + 8'd1) == end_q) state_d = S_ROW_END;
          else if (!col_hit)         state_d = S_COL_RD;
          else if (!val_hit)         state_d = S_VAL_RD;
          else                       state_d = S_EMIT;
        end
      end
      S_ROW_END:   state_d = row_last ? S_DONE : S_ROW_SETUP;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath registers: latched inputs, pointer word, caches, row/index counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      num_rows_q <= '0;
      row_q      <= '0;
      ptr_addr_q <= '0;
      col_addr_q <= '0;
      val_addr_q <= '0;
      ptr_word_q <= '0;
      col_word_q <= '0;
      val_word_q <= '0;
      col_tag_q  <= '0;
      val_tag_q  <= '0;
      col_vld_q  <= 1'b0;
      val_vld_q  <= 1'b0;
      k_q        <= '0;
      end_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: if (i_start) begin
          num_rows_q <= i_num_rows;
          ptr_addr_q <= i_ptr_addr;
          col_addr_q <= i_col_addr;
          val_addr_q <= i_val_addr;
          row_q      <= '0;
          col_vld_q  <= 1'b0;
          val_vld_q  <= 1'b0;
        end
        S_PTR_CAP:   ptr_word_q <= i_rd_data;
        S_ROW_SETUP: begin
          k_q   <= p_r;
          end_q <= p_r1;
        end
        S_COL_CAP: begin
          col_word_q <= i_rd_data;
          col_tag_q  <= col_need;
          col_vld_q  <= 1'b1;
        end
        S_VAL_CAP: begin
          val_word_q <= i_rd_data;
          val_tag_q  <= val_need;
          val_vld_q  <= 1'b1;
        end
        S_EMIT:    if (i_nz_ready) k_q <= k_q + 8'd1;
        S_ROW_END: if (!row_last) row_q <= row_q + 5'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; idle state drives everything to zero.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_rd_en    = (state_q == S_PTR_RD) || (state_q == S_COL_RD) || (state_q == S_VAL_RD);
    o_rd_addr  = '0;
    if (state_q == S_PTR_RD)      o_rd_addr = ptr_addr_q;
    else if (state_q == S_COL_RD) o_rd_addr = col_need;
    else if (state_q == S_VAL_RD) o_rd_addr = val_need;
    o_nz_valid = (state_q == S_EMIT);
    o_nz_row   = o_nz_valid ? row_q : '0;
    o_nz_col   = o_nz_valid ? col_word_q[{k_q[5:0], 2'b00} +: 4] : '0;
    o_nz_val   = o_nz_valid ? val_word_q[{k_q[3:0], 4'b0000} +: 16] : '0;
    o_row_done = (state_q == S_ROW_END);
    o_done_row = o_row_done ? row_q : '0;
    o_done     = done_q;
  end

endmodule

// File: tb/tb_spmv_row_sequencer.sv
// Self-checking bench: event-stream model of the CSR walk, SRAM model,
// randomized matrices and back-pressure, plus directed corner cases.
module tb_spmv_row_sequencer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [4:0]   num_rows;
  logic [4:0]   ptr_addr, col_addr, val_addr;
  logic         rd_en;
  logic [4:0]   rd_addr;
  logic [255:0] rd_data = '0;
  logic         nz_valid, nz_ready;
  logic [4:0]   nz_row;
  logic [3:0]   nz_col;
  logic [15:0]  nz_val;
  logic         row_done;
  logic [4:0]   done_row;
  logic         busy, done;

  spmv_row_sequencer #(.ADDR_W(5), .DATA_W(256)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_num_rows(num_rows),
    .i_ptr_addr(ptr_addr), .i_col_addr(col_addr), .i_val_addr(val_addr),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_nz_valid(nz_valid), .i_nz_ready(nz_ready), .o_nz_row(nz_row),
    .o_nz_col(nz_col), .o_nz_val(nz_val), .o_row_done(row_done),
    .o_done_row(done_row), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [4:0]  row;
    logic [3:0]  col;
    logic [15:0] val;
  } ev_t;

  logic [255:0] mem [32];
  ev_t          exp_q[$];
  int           exp_reads;
  int           rd_cnt;
  int           done_seen;
  int           total = 0;
  int           bad = 0;
  logic         chk_en = 1'b0;
  int           ready_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SRAM: one-cycle read latency, junk on the bus when not reading.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_en) begin
        rd_data <= mem[rd_addr];
        rd_cnt++;
      end else begin
        rd_data <= {8{$urandom}};
      end
    end
  end

  // Back-pressure: 0 always ready, 1 one-of-three, 2 random, 3 never.
  initial begin
    int rc;
    rc = 0;
    nz_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (ready_mode)
        0:       nz_ready = 1'b1;
        1:       nz_ready = (rc % 3) == 0;
        2:       nz_ready = ($urandom_range(0, 3) != 0);
        default: nz_ready = 1'b0;
      endcase
    end
  end

  // Expected event stream: every non-zero in CSR order, then that row's done.
  // Reads: pointer word plus one per change of column word / value word.
  task automatic build_model(input int nr, input logic [4:0] pa, input logic [4:0] ca,
                             input logic [4:0] va);
    logic [255:0] pw, cw, vw;
    int last_c, last_v, ks, ke, ci, vi;
    ev_t e;
    exp_q.delete();
    exp_reads = (nr == 0) ? 0 : 1;
    last_c = -1;
    last_v = -1;
    pw = mem[pa];
    for (int r = 0; r < nr; r++) begin
      ks = int'(pw[8*r +: 8]);
      ke = int'(pw[8*(r+1) +: 8]);
      for (int k = ks; k < ke; k++) begin
        ci = k / 64;
        vi = k / 16;
        if (ci != last_c) begin exp_reads++; last_c = ci; end
        if (vi != last_v) begin exp_reads++; last_v = vi; end
        cw = mem[5'(int'(ca) + ci)];
        vw = mem[5'(int'(va) + vi)];
        e.is_done = 1'b0;
        e.row = 5'(r);
        e.col = cw[4*(k%64) +: 4];
        e.val = vw[16*(k%16) +: 16];
        exp_q.push_back(e);
      end
      e.is_done = 1'b1;
      e.row = 5'(r);
      e.col = '0;
      e.val = '0;
      exp_q.push_back(e);
    end
  endtask

  // Compare process: stream order, stall stability, exclusivity of row_done.
  initial begin
    logic        stalled;
    logic [24:0] held;
    ev_t         e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        stalled = 1'b0;
      end else begin
        chk("valid_and_rowdone", {63'd0, nz_valid & row_done}, 64'd0);
        if (stalled) begin
          chk("stall_valid", {63'd0, nz_valid}, 64'd1);
          chk("stall_data", {39'd0, nz_row, nz_col, nz_val}, {39'd0, held});
        end
        if (nz_valid && nz_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL nz_extra: got row %0d col %0d val %0h expected none", nz_row, nz_col, nz_val);
          end else begin
            e = exp_q.pop_front();
            chk("nz_event", {38'd0, 1'b0, nz_row, nz_col, nz_val}, {38'd0, e});
          end
        end
        if (row_done) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rowdone_extra: got row %0d expected none", done_row);
          end else begin
            e = exp_q.pop_front();
            chk("rowdone_event", {38'd0, 1'b1, done_row, 20'd0}, {38'd0, e});
          end
        end
        if (done) done_seen++;
        stalled = nz_valid && !nz_ready;
        held = {nz_row, nz_col, nz_val};
      end
    end
  end

  task automatic pulse_start(input int nr, input logic [4:0] pa, input logic [4:0] ca,
                             input logic [4:0] va);
    @(posedge clk);
    #1;
    num_rows = 5'(nr);
    ptr_addr = pa;
    col_addr = ca;
    val_addr = va;
    rd_cnt = 0;
    done_seen = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One full run; lat = cycles from start sample to o_done.
  task automatic run_matrix(input int nr, input logic [4:0] pa, input logic [4:0] ca,
                            input logic [4:0] va, input int mode, input bit noise,
                            input int budget, output int lat);
    bit got;
    build_model(nr, pa, ca, va);
    ready_mode = mode;
    pulse_start(nr, pa, ca, va);
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) chk("busy_after_start", {63'd0, busy}, 64'd1);
      if (done) begin
        got = 1'b1;
        lat = n;
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        break;
      end
      if (noise && busy && ($urandom_range(0, 7) == 0)) begin
        start = 1'b1;
        num_rows = 5'($urandom);
        ptr_addr = 5'($urandom);
        col_addr = 5'($urandom);
        val_addr = 5'($urandom);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: got no o_done expected one within %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_seen), 64'd1);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("sram_reads", 64'(rd_cnt), 64'(exp_reads));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = {8{$urandom}};
  endtask

  task automatic set_ptr(input logic [4:0] a, input int n, input int vals[32]);
    logic [255:0] w;
    w = '0;
    for (int j = 0; j < n; j++) w[8*j +: 8] = 8'(vals[j]);
    mem[a] = w;
  endtask

  task automatic setup_directed();
    int p[32];
    int cols[6] = '{0, 3, 7, 11, 13, 14};
    logic [15:0] vals[6] = '{16'h3C1F, 16'h4533, 16'h4700, 16'h4233, 16'h4900, 16'h4000};
    fill_random();
    p = '{default: 0};
    p[0] = 0; p[1] = 1; p[2] = 3; p[3] = 3; p[4] = 5; p[5] = 6;
    set_ptr(5'd2, 6, p);
    for (int k = 0; k < 6; k++) begin
      mem[5][4*k +: 4] = 4'(cols[k]);
      mem[9][16*k +: 16] = vals[k];
    end
  endtask

  initial begin
    int lat, nr, pv;
    int p[32];
    logic [4:0] pa, ca, va;
    bit seen;
    rstn = 1'b0;
    start = 1'b0;
    num_rows = '0;
    ptr_addr = '0;
    col_addr = '0;
    val_addr = '0;
    fill_random();
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("rst_nz_valid", {63'd0, nz_valid}, 64'd0);
    chk("rst_row_done", {63'd0, row_done}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk_en = 1'b1;

    // Directed matrix; pin the model with hand-derived values first.
    setup_directed();
    build_model(5, 5'd2, 5'd5, 5'd9);
    chk("model_len", 64'(exp_q.size()), 64'd11);
    chk("model_ev0", 64'(exp_q[0]), {38'd0, 1'b0, 5'd0, 4'd0, 16'h3C1F});
    chk("model_ev3", 64'(exp_q[3]), {38'd0, 1'b0, 5'd1, 4'd7, 16'h4700});
    chk("model_ev5", 64'(exp_q[5]), {38'd0, 1'b1, 5'd2, 4'd0, 16'h0000});
    chk("model_ev9", 64'(exp_q[9]), {38'd0, 1'b0, 5'd4, 4'd14, 16'h4000});
    chk("model_reads", 64'(exp_reads), 64'd3);
    run_matrix(5, 5'd2, 5'd5, 5'd9, 0, 1'b0, 200, lat);
    run_matrix(5, 5'd2, 5'd5, 5'd9, 1, 1'b0, 400, lat);

    // Empty matrix: done two cycles after the start sample, no reads.
    run_matrix(0, 5'd2, 5'd5, 5'd9, 0, 1'b0, 20, lat);
    chk("zero_rows_latency", 64'(lat), 64'd2);
    chk("zero_rows_reads", 64'(rd_cnt), 64'd0);

    // 70 non-zeros in one row: 2 column words, 5 value words.
    fill_random();
    p = '{default: 0};
    p[0] = 0; p[1] = 70;
    set_ptr(5'd0, 2, p);
    build_model(1, 5'd0, 5'd1, 5'd3);
    chk("long_model_len", 64'(exp_q.size()), 64'd71);
    chk("long_model_reads", 64'(exp_reads), 64'd8);
    run_matrix(1, 5'd0, 5'd1, 5'd3, 0, 1'b0, 300, lat);
    chk("long_latency", 64'(lat), 64'd90);
    run_matrix(1, 5'd0, 5'd1, 5'd3, 2, 1'b1, 600, lat);

    // Malformed pointer p[1]=5, p[2]=2: row 1 empty, others unaffected.
    fill_random();
    p = '{default: 0};
    p[0] = 0; p[1] = 5; p[2] = 2; p[3] = 4; p[4] = 6;
    set_ptr(5'd7, 5, p);
    build_model(4, 5'd7, 5'd8, 5'd10);
    chk("malformed_model_len", 64'(exp_q.size()), 64'd13);
    chk("malformed_model_ev6", 64'(exp_q[6]), {38'd0, 1'b1, 5'd1, 20'd0});
    run_matrix(4, 5'd7, 5'd8, 5'd10, 2, 1'b0, 400, lat);

    // Reset while a non-zero is being offered.
    setup_directed();
    chk_en = 1'b0;
    ready_mode = 3;
    pulse_start(5, 5'd2, 5'd5, 5'd9);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (nz_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL emit_timeout: got no o_nz_valid expected one within 50 cycles");
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_nz_valid", {63'd0, nz_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("midrst_outs", {38'd0, nz_row, nz_col, nz_val, done_row}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    chk_en = 1'b1;
    run_matrix(5, 5'd2, 5'd5, 5'd9, 0, 1'b0, 200, lat);

    // Randomized matrices, back-pressure and ignored start pulses.
    for (int it = 0; it < 25; it++) begin
      fill_random();
      nr = $urandom_range(1, 31);
      if ($urandom_range(0, 7) == 0) nr = 0;
      pa = 5'($urandom);
      ca = 5'($urandom);
      va = 5'($urandom);
      pv = $urandom_range(0, 40);
      for (int j = 0; j < 32; j++) begin
        p[j] = pv;
        if ($urandom_range(0, 9) == 0) pv = (pv > 8) ? pv - $urandom_range(1, 8) : 0;
        else pv = (pv + $urandom_range(0, 10) > 255) ? 255 : pv + $urandom_range(0, 10);
      end
      set_ptr(pa, 32, p);
      run_matrix(nr, pa, ca, va, $urandom_range(0, 2), 1'b1, 4000, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spmv_row_sequencer.md
# spmv_row_sequencer

CSR row sequencer for the SpMV engine: walks the row-pointer array, fetches packed column-index and FP16 value words from the shared 256-bit SRAM read port, and streams one non-zero per handshake to the MAC datapath, tagged with its row. It sits between the ops controller, which supplies the base addresses and start pulse, and the multiply-accumulate core, which consumes the stream and closes each row on `o_row_done`.

## Interface
Parameters:
- `ADDR_W`, 5: SRAM word-address width.
- `DATA_W`, 256: SRAM word width (fixed packing below assumes 256).

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle start pulse; ignored while `o_busy`.
- `i_num_rows`  in  5  number of rows, 0..31.
- `i_ptr_addr` / `i_col_addr` / `i_val_addr`  in  ADDR_W  base word addresses of row-pointer, column-index, value arrays.
- `o_rd_en`  out  1  SRAM read strobe.
- `o_rd_addr`  out  ADDR_W  SRAM read address.
- `i_rd_data`  in  DATA_W  read data, valid the cycle after `o_rd_en`.
- `o_nz_valid`  out  1  non-zero available.
- `i_nz_ready`  in  1  MAC accepts non-zero.
- `o_nz_row`  out  5  row index of current non-zero.
- `o_nz_col`  out  4  column index.
- `o_nz_val`  out  16  FP16 value.
- `o_row_done`  out  1  one-cycle pulse: row `o_done_row` fully issued (also for empty rows).
- `o_done_row`  out  5  row index qualified by `o_row_done`.
- `o_busy`  out  1  high from accepted start until done.
- `o_done`  out  1  one-cycle pulse at end of matrix.

## Operation
- Packing: row pointer `p[j]` = bits [8j+7:8j] of the pointer word (32 entries, single word). Column index `k` = nibble `k[5:0]` of word `i_col_addr + k[7:6]`. Value `k` = halfword `k[3:0]` of word `i_val_addr + k[7:4]`. Non-zero index `k` is 8-bit.
- FSM: IDLE → PTR_RD → PTR_CAP → ROW_SETUP → (COL_RD → COL_CAP)? → (VAL_RD → VAL_CAP)? → EMIT → ROW_END → ROW_SETUP … → DONE → IDLE.
- IDLE: on `i_start`, latch inputs; if `i_num_rows == 0` go to DONE directly (no reads).
- PTR_CAP: latch the 256-bit pointer word into a local register.
- ROW_SETUP: `k ← p[r]`, `end ← p[r+1]`; if `end <= k` (empty or malformed) go to ROW_END.
- Word caches: one column-word and one value-word register, each with a tag (word address) and valid bit, cleared on start. COL_RD/VAL_RD are entered only when the needed tag misses; hits go straight to EMIT.
- EMIT: drive `o_nz_valid` with row/col/val of `k`; on handshake `k ← k+1`; if `k+1 == end` go to ROW_END, else re-check caches (miss on crossing a 64-nibble / 16-halfword boundary).
- ROW_END: pulse `o_row_done` with `o_done_row = r`; if `r+1 == num_rows` go to DONE else `r ← r+1`, ROW_SETUP.
- DONE: pulse `o_done`, drop `o_busy`, return to IDLE.
- Read port is used for one word at a time; column fetch always precedes value fetch.

## Timing
- Reset: all outputs 0, FSM IDLE, cache valids cleared, takes effect immediately regardless of state; no `o_done` is produced for an interrupted run.
- `o_busy` rises the cycle after `i_start` sampled; `o_rd_en` for pointer word in that same cycle.
- Read latency 1: `o_rd_en`/`o_rd_addr` in cycle t, data captured at end of t+1; each miss costs 2 cycles.
- `o_nz_valid` stays high with stable row/col/val until `i_nz_ready`; no combinational path from `i_nz_ready` to `o_rd_en`.
- With both caches hit and `i_nz_ready` held high: one non-zero per cycle within a row.
- `o_row_done` is never asserted in the same cycle as `o_nz_valid`; each row produces exactly one `o_row_done`, rows in ascending order.
- `i_start` while busy: ignored, no state change.

## Test plan
- Reset mid-EMIT (`i_rstn` low for 1 cycle) -> all outputs 0 next cycle, no `o_done`; fresh `i_start` then runs correctly.
- `i_num_rows=5`, ptr word bytes 0,1,3,3,5,6, cols nibbles 0,3,7,11,13,14, vals 0x3C1F,0x4533,0x4700,0x4233,0x4900,0x4000, `i_nz_ready=1` -> stream (r0,c0,3C1F),(r1,c3,4533),(r1,c7,4700),(r3,c11,4233),(r3,c13,4900),(r4,c14,4000); `o_row_done` for rows 0..4 including empty row 2; exactly 3 SRAM reads; `o_done` once.
- Same matrix, `i_nz_ready` toggling 1-of-3 cycles -> identical stream, outputs stable while stalled.
- `i_num_rows=0` -> `o_done` pulse two cycles after start, zero `o_rd_en`.
- Single row with 70 non-zeros -> col word refetched at k=64, value word refetched at k=16,32,48,64; 70 transfers, one `o_row_done`.
- Malformed ptr p[1]=5, p[2]=2 -> row 1 treated empty, only `o_row_done` for it, next rows unaffected.
